// File: rtl/unidade_controle_pkg.sv
// State codes for the memory-game control unit; db_estado carries these values.
package unidade_controle_pkg;

  localparam logic [3:0] INICIAL           = 4'h0;
  localparam logic [3:0] PREPARACAO        = 4'h1;
  localparam logic [3:0] CARREGA_DADO      = 4'h2;
  localparam logic [3:0] MOSTRA_DADO       = 4'h3;
  localparam logic [3:0] FIM_MOSTRA        = 4'h4;
  localparam logic [3:0] INCREMENTA_MOSTRA = 4'h5;
  localparam logic [3:0] INICIO_RODADA     = 4'h6;
  localparam logic [3:0] ESPERA_JOGADA     = 4'h7;
  localparam logic [3:0] REGISTRA_JOGADA   = 4'h8;
  localparam logic [3:0] COMPARA           = 4'h9;
  localparam logic [3:0] PROXIMA_JOGADA    = 4'hA;
  localparam logic [3:0] ULTIMA_JOGADA     = 4'hB;
  localparam logic [3:0] ACERTOU           = 4'hC;
  localparam logic [3:0] ERROU             = 4'hD;
  localparam logic [3:0] FIM_TIMEOUT       = 4'hE;
  localparam logic [3:0] PROXIMA_SEQUENCIA = 4'hF;

endpackage

// File: rtl/unidade_controle.sv
// Moore FSM sequencing the memory-game datapath: replay phase, then player phase.
// Define JOGO_TIMEOUT_EN to let the timeout input end the game from espera_jogada.
module unidade_controle
  import unidade_controle_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       jogada_feita,
  input  logic       chavesIgualMemoria,
  input  logic       enderecoIgualSequencia,
  input  logic       fimL,
  input  logic       fimTMR,
  input  logic       timeout,
  output logic       zeraR,
  output logic       zeraE,
  output logic       zeraL,
  output logic       zeraM,
  output logic       zeraTMR,
  output logic       registraR,
  output logic       registraM,
  output logic       contaE,
  output logic       contaL,
  output logic       contaTMR,
  output logic       pronto,
  output logic       ganhou,
  output logic       perdeu,
  output logic [3:0] db_estado
);

`ifdef JOGO_TIMEOUT_EN
  localparam logic TMO_EN = 1'b1;
`else
  localparam logic TMO_EN = 1'b0;
`endif

  logic [3:0] estado_q, estado_d;
  logic       timeout_ativo;

  assign timeout_ativo = timeout & TMO_EN;

  always_ff @(posedge clock) begin
    if (reset) estado_q <= INICIAL;
    else       estado_q <= estado_d;
  end

  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      INICIAL:           if (iniciar) estado_d = PREPARACAO;
      PREPARACAO:        estado_d = CARREGA_DADO;
      CARREGA_DADO:      estado_d = MOSTRA_DADO;
      MOSTRA_DADO:       if (fimTMR) estado_d = FIM_MOSTRA;
      FIM_MOSTRA:        estado_d = enderecoIgualSequencia ? INICIO_RODADA : INCREMENTA_MOSTRA;
      INCREMENTA_MOSTRA: estado_d = CARREGA_DADO;
      INICIO_RODADA:     estado_d = ESPERA_JOGADA;
      ESPERA_JOGADA: begin
        // timeout wins over a simultaneous press
        if (timeout_ativo)     estado_d = FIM_TIMEOUT;
        else if (jogada_feita) estado_d = REGISTRA_JOGADA;
      end
      REGISTRA_JOGADA:   estado_d = COMPARA;
      COMPARA: begin
        if (!chavesIgualMemoria)         estado_d = ERROU;
        else if (enderecoIgualSequencia) estado_d = ULTIMA_JOGADA;
        else                             estado_d = PROXIMA_JOGADA;
      end
      PROXIMA_JOGADA:    estado_d = ESPERA_JOGADA;
      ULTIMA_JOGADA:     estado_d = fimL ? ACERTOU : PROXIMA_SEQUENCIA;
      PROXIMA_SEQUENCIA: estado_d = CARREGA_DADO;
      ACERTOU, ERROU, FIM_TIMEOUT: if (iniciar) estado_d = PREPARACAO;
      default:           estado_d = INICIAL;
    endcase
  end

  always_comb begin
    zeraR     = 1'b0;
    zeraE     = 1'b0;
    zeraL     = 1'b0;
    zeraM     = 1'b0;
    zeraTMR   = 1'b0;
    registraR = 1'b0;
    registraM = 1'b0;
    contaE    = 1'b0;
    contaL    = 1'b0;
    contaTMR  = 1'b0;
    pronto    = 1'b0;
    ganhou    = 1'b0;
    perdeu    = 1'b0;
    db_estado = estado_q;
    case (estado_q)
      PREPARACAO: begin
        zeraE = 1'b1; zeraL = 1'b1; zeraR = 1'b1; zeraM = 1'b1; zeraTMR = 1'b1;
      end
      CARREGA_DADO:      zeraTMR = 1'b1;
      MOSTRA_DADO:       begin registraM = 1'b1; contaTMR = 1'b1; end
      INCREMENTA_MOSTRA: contaE = 1'b1;
      INICIO_RODADA:     begin zeraE = 1'b1; zeraR = 1'b1; end
      ESPERA_JOGADA:     registraM = 1'b1;
      REGISTRA_JOGADA:   begin registraR = 1'b1; registraM = 1'b1; end
      COMPARA:           registraM = 1'b1;
      PROXIMA_JOGADA:    contaE = 1'b1;
      PROXIMA_SEQUENCIA: begin contaL = 1'b1; zeraE = 1'b1; end
      ACERTOU:           begin pronto = 1'b1; ganhou = 1'b1; end
      ERROU, FIM_TIMEOUT: begin pronto = 1'b1; perdeu = 1'b1; end
      default: ;
    endcase
  end

endmodule
